// File: rtl/thin_pass_if.sv
// Handshake and control bundle between the thinning pass scheduler and its
// host write port / padded RAM / kernel-mask datapath.
interface thin_pass_if #(
    parameter int N = 8
);
    localparam int bitSize = $clog2(N * N);

    logic               we;
    logic               load_wr;
    logic [bitSize-1:0] pix_addr;
    logic               win_valid;
    logic               win_ready;
    logic               res_valid;
    logic               res_del;
    logic               del_wr;
    logic [bitSize-1:0] del_addr;
    logic               sub_iter;
    logic [7:0]         iter_count;
    logic               busy;
    logic               done;

    // Scheduler side
    modport master (
        input  we, win_ready, res_valid, res_del,
        output load_wr, pix_addr, win_valid, del_wr, del_addr,
               sub_iter, iter_count, busy, done
    );

    // Host / datapath side
    modport slave (
        output we, win_ready, res_valid, res_del,
        input  load_wr, pix_addr, win_valid, del_wr, del_addr,
               sub_iter, iter_count, busy, done
    );
endinterface

// File: rtl/thin_pass_scheduler.sv
// Sequencer for the iterative thinning datapath: load N*N pixels, then run
// passes of two sub-iterations (scan, drain results, commit deletions) until a
// pass deletes nothing or MAX_ITER passes have completed.
module thin_pass_scheduler #(
    parameter int N        = 8,
    parameter int MAX_ITER = 16
) (
    input  logic          clk,
    input  logic          rst,
    thin_pass_if.master   bus
);
    localparam int bitSize = $clog2(N * N);
    localparam int PIX     = N * N;

    // Counters carry one extra bit so the value N*N itself is representable.
    localparam logic [bitSize:0] PIX_CNT = (bitSize + 1)'(PIX);
    localparam logic [bitSize:0] LAST    = (bitSize + 1)'(PIX - 1);
    localparam logic [bitSize:0] ONE     = (bitSize + 1)'(1);
    localparam logic [7:0]       MAX_CNT = 8'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE, LOAD, SCAN, DRAIN, COMMIT, CHECK, DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [bitSize:0]   load_idx_reg, iss_idx_reg, res_idx_reg, cm_idx_reg;
    logic               sub_iter_reg;
    logic [7:0]         iter_reg;
    logic               changed_reg;
    logic [PIX-1:0]     bitmap_reg;

    logic start_load;
    logic res_accept;
    logic pass_last;

    // A write in IDLE or DONE begins a fresh image load at address 0.
    assign start_load = ((state_reg == IDLE) || (state_reg == DONE)) && bus.we;
    // Results are only meaningful while a scan is outstanding.
    assign res_accept = ((state_reg == SCAN) || (state_reg == DRAIN)) &&
                        bus.res_valid && (res_idx_reg < PIX_CNT);
    // The pass that is closing now is the final one.
    assign pass_last  = !changed_reg || ((iter_reg + 8'd1) == MAX_CNT);

    assign bus.sub_iter   = sub_iter_reg;
    assign bus.iter_count = iter_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state decode and per-state output drive.
    always_comb begin
        state_next    = state_reg;
        bus.load_wr   = 1'b0;
        bus.pix_addr  = '0;
        bus.win_valid = 1'b0;
        bus.del_wr    = 1'b0;
        bus.del_addr  = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.we) begin
                    bus.load_wr = 1'b1;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                bus.busy     = 1'b1;
                bus.load_wr  = bus.we;
                bus.pix_addr = load_idx_reg[bitSize-1:0];
                if (bus.we && (load_idx_reg == LAST)) state_next = SCAN;
            end
            SCAN: begin
                bus.busy      = 1'b1;
                bus.win_valid = 1'b1;
                bus.pix_addr  = iss_idx_reg[bitSize-1:0];
                if (bus.win_ready && (iss_idx_reg == LAST)) state_next = DRAIN;
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (res_idx_reg == PIX_CNT) state_next = COMMIT;
            end
            COMMIT: begin
                bus.busy     = 1'b1;
                bus.del_wr   = bitmap_reg[cm_idx_reg[bitSize-1:0]];
                bus.del_addr = cm_idx_reg[bitSize-1:0];
                if (cm_idx_reg == LAST) state_next = CHECK;
            end
            CHECK: begin
                bus.busy = 1'b1;
                if (sub_iter_reg && pass_last) state_next = DONE;
                else                           state_next = SCAN;
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.we) begin
                    bus.load_wr = 1'b1;
                    state_next  = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Load, issue and commit counters plus sub-iteration / pass bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_idx_reg <= '0;
            iss_idx_reg  <= '0;
            cm_idx_reg   <= '0;
            sub_iter_reg <= 1'b0;
            iter_reg     <= '0;
        end else begin
            if (start_load) begin
                load_idx_reg <= ONE;
                iss_idx_reg  <= '0;
                cm_idx_reg   <= '0;
                sub_iter_reg <= 1'b0;
                iter_reg     <= '0;
            end
            if ((state_reg == LOAD) && bus.we)        load_idx_reg <= load_idx_reg + ONE;
            if ((state_reg == SCAN) && bus.win_ready) iss_idx_reg  <= iss_idx_reg + ONE;
            if (state_reg == COMMIT)                  cm_idx_reg   <= cm_idx_reg + ONE;
            if (state_reg == CHECK) begin
                iss_idx_reg <= '0;
                cm_idx_reg  <= '0;
                if (!sub_iter_reg) begin
                    sub_iter_reg <= 1'b1;
                end else begin
                    iter_reg <= iter_reg + 8'd1;
                    if (!pass_last) sub_iter_reg <= 1'b0;
                end
            end
        end
    end

    // In-order result index and the "something was deleted this pass" flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_idx_reg <= '0;
            changed_reg <= 1'b0;
        end else begin
            if (start_load) begin
                res_idx_reg <= '0;
                changed_reg <= 1'b0;
            end
            if (res_accept)                res_idx_reg <= res_idx_reg + ONE;
            if (res_accept && bus.res_del) changed_reg <= 1'b1;
            if (state_reg == CHECK) begin
                res_idx_reg <= '0;
                if (sub_iter_reg && !pass_last) changed_reg <= 1'b0;
            end
        end
    end

    // Deletion bitmap: one flop per pixel, set from results, cleared as COMMIT visits it.
    generate
        for (genvar gi = 0; gi < PIX; gi++) begin : g_bitmap
            always_ff @(posedge clk) begin
                if (rst) begin
                    bitmap_reg[gi] <= 1'b0;
                end else if (res_accept && (res_idx_reg[bitSize-1:0] == bitSize'(gi))) begin
                    bitmap_reg[gi] <= bus.res_del;
                end else if ((state_reg == COMMIT) && (cm_idx_reg[bitSize-1:0] == bitSize'(gi))) begin
                    bitmap_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate
endmodule
